// File: rtl/tt_um_uabc_cert_uart.sv
// Tiny Tapeout user top for the UABC certificate project: strobed byte capture into a
// FIFO, drained by a UART transmitter with optional per-frame parity.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ena      design selected; low blocks the start of new frames
//   ui_in    [0] write strobe, [1] clear, [2] parity enable, [3] parity odd, [7:4] unused
//   uio_in   data byte to enqueue
//   uo_out   [0] tx, [1] busy, [2] full, [3] empty, [4] sticky overflow, [7:5] min(count,7)
//   uio_out  tied 0
//   uio_oe   tied 0 (all uio pins are inputs)
module tt_um_uabc_cert_uart #(
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = $clog2(CLK_DIV);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // ---------------------------------------------------------------------------
  // Control synchronisers and write edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] wr_sync_q, clr_sync_q;
  logic                   wr_prev_q;
  logic                   wr_fire, clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync_q  <= '0;
      clr_sync_q <= '0;
      wr_prev_q  <= 1'b0;
    end else begin
      wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], ui_in[0]};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], ui_in[1]};
      wr_prev_q  <= wr_sync_q[SYNC_STAGES-1];
    end
  end

  assign wr_fire = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;
  assign clr     = clr_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, empty, push, pop;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // Fullness is judged before any same-cycle pop, so a write into a full FIFO is lost.
  assign push  = wr_fire & ~clr & ~full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_fire && full) overflow_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: reset clears the pointers, which discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uio_in;
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  logic [2:0]      state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic            timer_end, can_start, tx, busy;

  assign timer_end = (tmr_q == TmrW'(CLK_DIV - 1));
  assign can_start = ena & ~empty & ~clr;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    pop       = 1'b0;

    if (state_q != StIdle) tmr_d = timer_end ? '0 : tmr_q + TmrW'(1);

    unique case (state_q)
      StIdle: begin
        if (can_start) begin
          pop       = 1'b1;
          state_d   = StStart;
          tmr_d     = '0;
          data_d    = mem_q[rd_ptr_q];
          par_en_d  = ui_in[2];
          par_odd_d = ui_in[3];
        end
      end
      StStart: begin
        if (timer_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (timer_end) begin
          if (bit_q == 3'd7) state_d = par_en_q ? StParity : StStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StParity: begin
        if (timer_end) state_d = StStop;
      end
      StStop: begin
        // Chain straight into the next start bit so back-to-back frames have no gap.
        if (timer_end) begin
          if (can_start) begin
            pop       = 1'b1;
            state_d   = StStart;
            data_d    = mem_q[rd_ptr_q];
            par_en_d  = ui_in[2];
            par_odd_d = ui_in[3];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tmr_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
    end
  end

  // tx decodes straight from state so an asynchronous reset forces it high at once.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      StIdle:   tx = 1'b1;
      StStart:  tx = 1'b0;
      StData:   tx = data_q[bit_q];
      StParity: tx = (^data_q) ^ par_odd_q;
      StStop:   tx = 1'b1;
      default:  tx = 1'b1;
    endcase
  end

  assign busy = (state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [4:0] count_ext;
  logic [2:0] count_sat;

  assign count_ext = 5'(count_q);
  assign count_sat = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];

  assign uo_out  = {count_sat, overflow_q, empty, full, busy, tx};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ui;
  assign unused_ui = ^ui_in[7:4];

endmodule

// File: tb/tb_tt_um_uabc_cert_uart.sv
module tb_tt_um_uabc_cert_uart;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errs;
  int checks;

  tt_um_uabc_cert_uart #(
    .CLK_DIV    (16),
    .FIFO_DEPTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Data held from strobe rise until well after the synchronised write fires.
  task automatic push_byte(input logic [7:0] b);
    uio_in   = b;
    ui_in[0] = 1'b1;
    cyc(4);
    ui_in[0] = 1'b0;
    cyc(2);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (uo_out[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Mid-bit sampling of one frame; optionally pulses clear during the start bit.
  task automatic recv_frame(input bit with_par, input bit pulse_clr, output logic [7:0] d,
                            output logic p, output logic stp, output bit ok);
    d   = 8'h00;
    p   = 1'b1;
    stp = 1'b0;
    wait_start(ok);
    if (!ok) return;
    if (pulse_clr) begin
      ui_in[1] = 1'b1;
      cyc(3);
      ui_in[1] = 1'b0;
      cyc(5);
    end else begin
      cyc(8);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(16);
      d[i] = uo_out[0];
    end
    if (with_par) begin
      cyc(16);
      p = uo_out[0];
    end
    cyc(16);
    stp = uo_out[0];
  endtask

  // Counts cycles with busy or a low tx over a window.
  task automatic quiet_window(input int n, output int activity);
    activity = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_out[1] || !uo_out[0]) activity++;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       p, stp;
    bit         ok;
    int         act;
    int         busy_cnt;
    int         good;
    logic       txs [160];
    logic [9:0] ef;

    errs     = 0;
    checks   = 0;
    rst_n    = 1'b1;
    ena      = 1'b0;
    ui_in    = 8'hA0;  // upper nibble is don't-care garbage
    uio_in   = 8'h00;
    #1 rst_n = 1'b0;
    cyc(3);
    check("reset_uo_out", 32'(uo_out), 32'h09);
    check("reset_uio_out", 32'(uio_out), 32'h00);
    check("reset_uio_oe", 32'(uio_oe), 32'h00);
    rst_n = 1'b1;

    // Idle with no strobe
    quiet_window(320, act);
    check("idle_quiet", 32'(act), 0);

    // 0xA5, no parity: per-cycle trace of the whole frame
    push_byte(8'hA5);
    check("a5_queued_count", 32'(uo_out[7:5]), 1);
    ena      = 1'b1;
    busy_cnt = 0;
    for (int n = 0; n < 160; n++) begin
      @(negedge clk);
      txs[n] = uo_out[0];
      if (uo_out[1]) busy_cnt++;
    end
    check("a5_busy_cycles", 32'(busy_cnt), 160);
    ef = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      good = 0;
      for (int k = 0; k < 16; k++) if (txs[b*16+k] == ef[b]) good++;
      check($sformatf("a5_bit%0d", b), 32'(good), 16);
    end
    @(negedge clk);
    check("a5_after_busy", 32'(uo_out[1]), 0);
    check("a5_after_empty", 32'(uo_out[3]), 1);
    check("a5_after_tx", 32'(uo_out[0]), 1);

    // 0x03, odd parity
    ena = 1'b0;
    push_byte(8'h03);
    ui_in[2] = 1'b1;
    ui_in[3] = 1'b1;
    ena      = 1'b1;
    recv_frame(1'b1, 1'b0, d, p, stp, ok);
    check("odd_started", 32'(ok), 1);
    check("odd_data", 32'(d), 32'h03);
    check("odd_parity", 32'(p), 1);
    check("odd_stop", 32'(stp), 1);
    ena = 1'b0;
    cyc(16);

    // 0x03, even parity
    push_byte(8'h03);
    ui_in[3] = 1'b0;
    ena      = 1'b1;
    recv_frame(1'b1, 1'b0, d, p, stp, ok);
    check("even_started", 32'(ok), 1);
    check("even_data", 32'(d), 32'h03);
    check("even_parity", 32'(p), 0);
    check("even_stop", 32'(stp), 1);
    ena = 1'b0;
    cyc(16);
    ui_in[2] = 1'b0;

    // Overfill with ena low, then drain in order
    for (int i = 0; i < 9; i++) push_byte(8'h41 + 8'(i));
    check("fill_full", 32'(uo_out[2]), 1);
    check("fill_empty", 32'(uo_out[3]), 0);
    check("fill_count", 32'(uo_out[7:5]), 7);
    check("fill_overflow", 32'(uo_out[4]), 1);
    check("fill_idle", 32'(uo_out[1]), 0);
    ena = 1'b1;
    for (int k = 0; k < 8; k++) begin
      recv_frame(1'b0, 1'b0, d, p, stp, ok);
      check($sformatf("drain_started%0d", k), 32'(ok), 1);
      check($sformatf("drain_byte%0d", k), 32'(d), 32'(8'h41 + 8'(k)));
      check($sformatf("drain_stop%0d", k), 32'(stp), 1);
    end
    cyc(16);
    check("drain_empty", 32'(uo_out[3]), 1);
    check("drain_overflow_sticky", 32'(uo_out[4]), 1);
    quiet_window(320, act);
    check("drain_no_ninth", 32'(act), 0);

    // Clear during the third frame
    ena = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'h51 + 8'(i));
    check("clr_pre_count", 32'(uo_out[7:5]), 6);
    ena = 1'b1;
    for (int k = 0; k < 3; k++) begin
      recv_frame(1'b0, (k == 2), d, p, stp, ok);
      check($sformatf("clr_started%0d", k), 32'(ok), 1);
      check($sformatf("clr_byte%0d", k), 32'(d), 32'(8'h51 + 8'(k)));
      check($sformatf("clr_stop%0d", k), 32'(stp), 1);
    end
    cyc(16);
    check("clr_overflow", 32'(uo_out[4]), 0);
    check("clr_empty", 32'(uo_out[3]), 1);
    check("clr_count", 32'(uo_out[7:5]), 0);
    quiet_window(320, act);
    check("clr_quiet", 32'(act), 0);

    // Asynchronous reset in the middle of DATA
    ena = 1'b0;
    push_byte(8'h00);
    push_byte(8'h00);
    ena = 1'b1;
    wait_start(ok);
    check("rst_started", 32'(ok), 1);
    cyc(40);
    check("rst_mid_busy", 32'(uo_out[1]), 1);
    check("rst_mid_tx", 32'(uo_out[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(uo_out[0]), 1);
    check("rst_async_busy", 32'(uo_out[1]), 0);
    check("rst_async_empty", 32'(uo_out[3]), 1);
    check("rst_async_uo", 32'(uo_out), 32'h09);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window(320, act);
    check("rst_no_residual", 32'(act), 0);
    check("rst_post_empty", 32'(uo_out[3]), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
